// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback/long-latency producers and the regfile write-port arbiter.
// Bypass lookup signals exist only when WBARB_BYPASS_EN is defined.
interface wb_port_arbiter_if #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              wbarb_i_a_we;
  logic [AWIDTH-1:0] wbarb_i_a_addr;
  logic [DWIDTH-1:0] wbarb_i_a_data;
  logic              wbarb_i_flush;
  logic              wbarb_i_b_valid;
  logic              wbarb_o_b_ready;
  logic [AWIDTH-1:0] wbarb_i_b_addr;
  logic [DWIDTH-1:0] wbarb_i_b_data;
  logic              wbarb_o_we;
  logic [AWIDTH-1:0] wbarb_o_addr;
  logic [DWIDTH-1:0] wbarb_o_data;
  logic              wbarb_o_stall;
  logic [CNT_W-1:0]  wbarb_o_count;
`ifdef WBARB_BYPASS_EN
  logic [AWIDTH-1:0] wbarb_i_rs_addr;
  logic              wbarb_o_rs_hit;
  logic [DWIDTH-1:0] wbarb_o_rs_data;

  modport master (
    output wbarb_i_a_we, wbarb_i_a_addr, wbarb_i_a_data, wbarb_i_flush,
    output wbarb_i_b_valid, wbarb_i_b_addr, wbarb_i_b_data, wbarb_i_rs_addr,
    input  wbarb_o_b_ready, wbarb_o_we, wbarb_o_addr, wbarb_o_data,
    input  wbarb_o_stall, wbarb_o_count, wbarb_o_rs_hit, wbarb_o_rs_data
  );

  modport slave (
    input  wbarb_i_a_we, wbarb_i_a_addr, wbarb_i_a_data, wbarb_i_flush,
    input  wbarb_i_b_valid, wbarb_i_b_addr, wbarb_i_b_data, wbarb_i_rs_addr,
    output wbarb_o_b_ready, wbarb_o_we, wbarb_o_addr, wbarb_o_data,
    output wbarb_o_stall, wbarb_o_count, wbarb_o_rs_hit, wbarb_o_rs_data
  );
`else
  modport master (
    output wbarb_i_a_we, wbarb_i_a_addr, wbarb_i_a_data, wbarb_i_flush,
    output wbarb_i_b_valid, wbarb_i_b_addr, wbarb_i_b_data,
    input  wbarb_o_b_ready, wbarb_o_we, wbarb_o_addr, wbarb_o_data,
    input  wbarb_o_stall, wbarb_o_count
  );

  modport slave (
    input  wbarb_i_a_we, wbarb_i_a_addr, wbarb_i_a_data, wbarb_i_flush,
    input  wbarb_i_b_valid, wbarb_i_b_addr, wbarb_i_b_data,
    output wbarb_o_b_ready, wbarb_o_we, wbarb_o_addr, wbarb_o_data,
    output wbarb_o_stall, wbarb_o_count
  );
`endif
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: fixed-priority writeback (A) vs. queued long-latency results (B).
// Optional feature macro: WBARB_BYPASS_EN adds a youngest-match lookup over queued B entries.
module wb_port_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic               wbarb_clk,
  input  logic               wbarb_rst,
  wb_port_arbiter_if.slave   bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [AWIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              stall_nxt;

  logic              we_p1;
  logic [AWIDTH-1:0] addr_p1;
  logic [DWIDTH-1:0] data_p1;
  logic              stall_p1;

  logic fifo_nempty;
  logic b_ready;
  logic push;
  logic a_eff;
  logic pop;
  logic a_grant;

  assign fifo_nempty = (count != '0);
  // Ready looks only at the pre-edge count, so a full queue refuses even while popping.
  assign b_ready     = (count < DEPTH_C);
  assign push        = bus.wbarb_i_b_valid & b_ready & (bus.wbarb_i_b_addr != '0);
  assign a_eff       = bus.wbarb_i_a_we & ~bus.wbarb_i_flush
                     & (bus.wbarb_i_a_addr != '0) & ~stall_p1;
  assign pop         = fifo_nempty & (stall_p1 | ~a_eff);
  assign a_grant     = a_eff & ~pop;

  always_comb begin
    wait_nxt  = wait_cnt;
    stall_nxt = stall_p1;
    if (pop || !fifo_nempty) begin
      wait_nxt  = '0;
      stall_nxt = 1'b0;
    end else if (a_grant) begin
      if (wait_cnt != MAX_WAIT_C) wait_nxt = wait_cnt + 1'b1;
      if (wait_nxt == MAX_WAIT_C) stall_nxt = 1'b1;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge wbarb_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wbarb_i_b_addr;
      fifo_data[wr_ptr] <= bus.wbarb_i_b_data;
    end
  end

  // p0 -> p1: grant decision registered onto the regfile write port
  always_ff @(posedge wbarb_clk or negedge wbarb_rst) begin
    if (!wbarb_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      stall_p1 <= 1'b0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      wait_cnt <= wait_nxt;
      stall_p1 <= stall_nxt;
      we_p1    <= pop | a_grant;
      if (pop) begin
        addr_p1 <= fifo_addr[rd_ptr];
        data_p1 <= fifo_data[rd_ptr];
      end else if (a_grant) begin
        addr_p1 <= bus.wbarb_i_a_addr;
        data_p1 <= bus.wbarb_i_a_data;
      end
    end
  end

  assign bus.wbarb_o_b_ready = b_ready;
  assign bus.wbarb_o_we      = we_p1;
  assign bus.wbarb_o_addr    = addr_p1;
  assign bus.wbarb_o_data    = data_p1;
  assign bus.wbarb_o_stall   = stall_p1;
  assign bus.wbarb_o_count   = count;

`ifdef WBARB_BYPASS_EN
  logic              rs_hit;
  logic [DWIDTH-1:0] rs_data;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rs_hit  = 1'b0;
    rs_data = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (bus.wbarb_i_rs_addr != '0)
          && (fifo_addr[idx] == bus.wbarb_i_rs_addr)) begin
        rs_hit  = 1'b1;
        rs_data = fifo_data[idx];
      end
    end
  end

  assign bus.wbarb_o_rs_hit  = rs_hit;
  assign bus.wbarb_o_rs_data = rs_data;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts each cycle's
// registered outputs, which are popped and compared one edge later, plus directed spot checks.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int MW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          stall;
    int            count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t                 sb[$];
  logic [AW+DW-1:0]     m_q[$];
  logic                 m_stall;
  int                   m_wait;
  logic [AW-1:0]        m_addr;
  logic [DW-1:0]        m_data;
  logic                 m_a_granted;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
    .wbarb_clk (clk),
    .wbarb_rst (rst_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_stall = 1'b0;
    m_wait  = 0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic model_step(input logic a_we, input logic [AW-1:0] a_addr,
                            input logic [DW-1:0] a_data, input logic fl, input logic bv,
                            input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    exp_t e;
    int   sz;
    logic aeff;
    logic popped;
    logic rdy;
    sz     = m_q.size();
    rdy    = (sz < DEPTH);
    aeff   = a_we && !fl && (a_addr != 0) && !m_stall;
    popped = 1'b0;
    m_a_granted = 1'b0;
    e.we   = 1'b0;
    if (sz > 0 && (m_stall || !aeff)) begin
      popped = 1'b1;
      {m_addr, m_data} = m_q.pop_front();
      e.we = 1'b1;
    end else if (aeff) begin
      m_a_granted = 1'b1;
      m_addr = a_addr;
      m_data = a_data;
      e.we = 1'b1;
    end
    if (popped || sz == 0) begin
      m_wait  = 0;
      m_stall = 1'b0;
    end else if (aeff) begin
      m_wait++;
      if (m_wait >= MW) m_stall = 1'b1;
    end
    if (bv && rdy && ba != 0) m_q.push_back({ba, bd});
    e.addr  = m_addr;
    e.data  = m_data;
    e.stall = m_stall;
    e.count = m_q.size();
    sb.push_back(e);
  endtask

  task automatic cycle(input logic a_we, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_data,
                       input logic fl, input logic bv, input logic [AW-1:0] ba,
                       input logic [DW-1:0] bd);
    exp_t e;
    bus.wbarb_i_a_we    = a_we;
    bus.wbarb_i_a_addr  = a_addr;
    bus.wbarb_i_a_data  = a_data;
    bus.wbarb_i_flush   = fl;
    bus.wbarb_i_b_valid = bv;
    bus.wbarb_i_b_addr  = ba;
    bus.wbarb_i_b_data  = bd;
    #1;
    check("b_ready", 64'(bus.wbarb_o_b_ready), 64'(m_q.size() < DEPTH));
    model_step(a_we, a_addr, a_data, fl, bv, ba, bd);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("o_we", 64'(bus.wbarb_o_we), 64'(e.we));
    check("o_addr", 64'(bus.wbarb_o_addr), 64'(e.addr));
    check("o_data", 64'(bus.wbarb_o_data), 64'(e.data));
    check("o_stall", 64'(bus.wbarb_o_stall), 64'(e.stall));
    check("o_count", 64'(bus.wbarb_o_count), 64'(e.count));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(bus.wbarb_o_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.wbarb_o_addr), 64'd0);
    check({tag, "_data"}, 64'(bus.wbarb_o_data), 64'd0);
    check({tag, "_stall"}, 64'(bus.wbarb_o_stall), 64'd0);
    check({tag, "_count"}, 64'(bus.wbarb_o_count), 64'd0);
  endtask

  initial begin
    int n;
    int stall_first;
    bus.wbarb_i_a_we    = 1'b0;
    bus.wbarb_i_a_addr  = '0;
    bus.wbarb_i_a_data  = '0;
    bus.wbarb_i_flush   = 1'b0;
    bus.wbarb_i_b_valid = 1'b0;
    bus.wbarb_i_b_addr  = '0;
    bus.wbarb_i_b_data  = '0;
`ifdef WBARB_BYPASS_EN
    bus.wbarb_i_rs_addr = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    #1;
    check("por_ready", 64'(bus.wbarb_o_b_ready), 64'd1);

    // A only
    cycle(1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b0, '0, '0);
    check("a_we", 64'(bus.wbarb_o_we), 64'd1);
    check("a_addr", 64'(bus.wbarb_o_addr), 64'd5);
    check("a_data", 64'(bus.wbarb_o_data), 64'hDEAD);
    cycle(1'b1, 5'd0, 32'hBEEF, 1'b0, 1'b0, '0, '0);
    check("a_addr0_we", 64'(bus.wbarb_o_we), 64'd0);

    // B only, back-to-back pushes
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 5'd7, 32'd1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 5'd8, 32'd2);
    check("b_r7_addr", 64'(bus.wbarb_o_addr), 64'd7);
    check("b_r7_data", 64'(bus.wbarb_o_data), 64'd1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    check("b_r8_addr", 64'(bus.wbarb_o_addr), 64'd8);
    check("b_r8_data", 64'(bus.wbarb_o_data), 64'd2);
    check("b_count0", 64'(bus.wbarb_o_count), 64'd0);
    idle(1);

    // Starvation: full queue under continuous A traffic, A held while stalled
    n = 0;
    stall_first = -1;
    for (int c = 0; c < 7; c++) begin
      logic bv;
      logic [AW-1:0] ba;
      bv = (c < 2);
      ba = (c == 0) ? 5'd10 : 5'd11;
      if (c == 5) begin
        bus.wbarb_i_a_we = 1'b1;
        #1;
        check("t4_ready_on_pop", 64'(bus.wbarb_o_b_ready), 64'd0);
      end
      cycle(1'b1, 5'd3, 32'h100 + 32'(n), 1'b0, bv, ba, 32'hB0 + 32'(c));
      if (m_a_granted) n++;
      if (bus.wbarb_o_stall && stall_first < 0) stall_first = c;
      if (c == 5) begin
        check("t4_pop_addr", 64'(bus.wbarb_o_addr), 64'd10);
        check("t4_pop_stall", 64'(bus.wbarb_o_stall), 64'd0);
      end
      if (c == 6) check("t4_held_a", 64'(bus.wbarb_o_data), 64'h105);
    end
    check("t4_stall_cycle", 64'(stall_first), 64'd4);
    idle(2);

    // Flush kills A, queued head goes out instead
    cycle(1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd12, 32'hC);
    cycle(1'b1, 5'd4, 32'h45, 1'b1, 1'b0, '0, '0);
    check("flush_addr", 64'(bus.wbarb_o_addr), 64'd12);
    check("flush_data", 64'(bus.wbarb_o_data), 64'hC);
    idle(1);

`ifdef WBARB_BYPASS_EN
    cycle(1'b1, 5'd1, 32'hAA, 1'b0, 1'b1, 5'd9, 32'h11);
    cycle(1'b1, 5'd1, 32'hAB, 1'b0, 1'b1, 5'd9, 32'h22);
    bus.wbarb_i_rs_addr = 5'd9;
    #1;
    check("byp_hit", 64'(bus.wbarb_o_rs_hit), 64'd1);
    check("byp_data", 64'(bus.wbarb_o_rs_data), 64'h22);
    bus.wbarb_i_rs_addr = 5'd0;
    #1;
    check("byp_zero", 64'(bus.wbarb_o_rs_hit), 64'd0);
    idle(3);
`endif

    // Asynchronous reset mid-operation with a queued entry and B still valid
    cycle(1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 5'd6, 32'h66);
    bus.wbarb_i_a_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.wbarb_i_b_valid = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.wbarb_o_b_ready), 64'd1);
    idle(1);
    check("mid_rst_discard", 64'(bus.wbarb_o_we), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] aa;
      logic [AW-1:0] ba;
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      ba = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      cycle(1'($urandom_range(0, 1)), aa, $urandom, ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), ba, $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
